// File: rtl/pipe_stall_ctrl_if.sv
// Pipeline <-> stall controller signal bundle: stall requests, commit events,
// fetch-busy status and the stall/flush/redirect controls returned to the pipe.
interface pipe_stall_ctrl_if;
  logic        stallreq_if_i;
  logic        stallreq_id_i;
  logic        stallreq_ex_i;
  logic        stallreq_mem_i;
  logic        exception_i;
  logic        eret_i;
  logic [31:0] epc_i;
  logic        if_busy_i;
  logic [3:0]  stall_o;
  logic        flush_o;
  logic        redirect_valid_o;
  logic [31:0] redirect_pc_o;
  logic        drop_fetch_o;

  modport master (
    output stallreq_if_i, stallreq_id_i, stallreq_ex_i, stallreq_mem_i,
    output exception_i, eret_i, epc_i, if_busy_i,
    input  stall_o, flush_o, redirect_valid_o, redirect_pc_o, drop_fetch_o
  );

  modport slave (
    input  stallreq_if_i, stallreq_id_i, stallreq_ex_i, stallreq_mem_i,
    input  exception_i, eret_i, epc_i, if_busy_i,
    output stall_o, flush_o, redirect_valid_o, redirect_pc_o, drop_fetch_o
  );
endinterface

// File: rtl/pipe_stall_ctrl.sv
// Central stall/flush/redirect controller for the 5-stage pipeline.
// Optional per-cause stall-cycle counters are built when STALL_PERF_CNT_EN is defined.
module pipe_stall_ctrl #(
  parameter logic [31:0] EXC_ENTRY = 32'hBFC00380,
  parameter int          PERF_W    = 32
) (
  input  logic              clk,
  input  logic              rst,
  pipe_stall_ctrl_if.slave  ctl,
  input  logic [1:0]        perf_sel_i,
  input  logic              perf_clr_i,
  output logic [PERF_W-1:0] perf_cnt_o
);

  typedef enum logic {RUN = 1'b0, WAIT_IF = 1'b1} state_e;

  state_e      state_q, state_d;
  logic [31:0] redir_pc_q, redir_pc_d;

  logic [3:0]  req;
  logic [3:0]  stall_dec;
  logic [3:0]  stall;
  logic        flush;
  logic        redir_valid;
  logic [31:0] redir_pc;
  logic        drop_fetch;
  logic        run_evt;

  assign req = {ctl.stallreq_mem_i, ctl.stallreq_ex_i, ctl.stallreq_id_i, ctl.stallreq_if_i};

  // A request from stage k holds every stage up to and including k.
  for (genvar gi = 0; gi < 4; gi++) begin : g_stall_dec
    assign stall_dec[gi] = |req[3:gi];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= RUN;
      redir_pc_q <= 32'h0;
    end else begin
      state_q    <= state_d;
      redir_pc_q <= redir_pc_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    redir_pc_d  = redir_pc_q;
    stall       = 4'b0000;
    flush       = 1'b0;
    redir_valid = 1'b0;
    redir_pc    = 32'h0;
    drop_fetch  = 1'b0;
    run_evt     = 1'b0;
    case (state_q)
      RUN: begin
        if (ctl.exception_i || ctl.eret_i) begin
          run_evt     = 1'b1;
          flush       = 1'b1;
          redir_valid = 1'b1;
          redir_pc    = ctl.exception_i ? EXC_ENTRY : ctl.epc_i;
          redir_pc_d  = redir_pc;
          if (ctl.if_busy_i) state_d = WAIT_IF;
        end else begin
          stall = stall_dec;
        end
      end
      WAIT_IF: begin
        // Pipeline holds only bubbles here; keep the redirect alive until the
        // in-flight fetch returns so its data can be discarded.
        stall       = 4'b0001;
        redir_valid = 1'b1;
        redir_pc    = redir_pc_q;
        drop_fetch  = 1'b1;
        if (!ctl.if_busy_i) state_d = RUN;
      end
      default: state_d = RUN;
    endcase
    if (rst) begin
      stall       = 4'b0000;
      flush       = 1'b0;
      redir_valid = 1'b0;
      redir_pc    = 32'h0;
      drop_fetch  = 1'b0;
    end
  end

  assign ctl.stall_o          = stall;
  assign ctl.flush_o          = flush;
  assign ctl.redirect_valid_o = redir_valid;
  assign ctl.redirect_pc_o    = redir_pc;
  assign ctl.drop_fetch_o     = drop_fetch;

`ifdef STALL_PERF_CNT_EN
  logic              count_en;
  logic [PERF_W-1:0] cnt_view [4];

  assign count_en = (state_q == RUN) && !run_evt && !rst;

  for (genvar gi = 0; gi < 4; gi++) begin : g_perf
    logic              top_req;
    logic [PERF_W-1:0] cnt_q;

    // Only the highest-numbered active cause is charged for the cycle.
    if (gi == 3) begin : g_top
      assign top_req = req[3];
    end else begin : g_low
      assign top_req = req[gi] && !(|req[3:gi+1]);
    end

    always_ff @(posedge clk) begin
      if (rst || perf_clr_i) begin
        cnt_q <= '0;
      end else if (count_en && top_req && (cnt_q != {PERF_W{1'b1}})) begin
        cnt_q <= cnt_q + 1'b1;
      end
    end

    assign cnt_view[gi] = cnt_q;
  end

  assign perf_cnt_o = rst ? '0 : cnt_view[perf_sel_i];
`else
  logic unused_perf;
  assign unused_perf = ^{perf_sel_i, perf_clr_i};
  assign perf_cnt_o  = '0;
`endif

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Self-checking bench for pipe_stall_ctrl: directed vector table, counter
// sequence, and randomized run against a behavioural model.
module tb_pipe_stall_ctrl;
  localparam logic [31:0] EXC = 32'hBFC00380;
  localparam int          PW  = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic [1:0]    perf_sel;
  logic          perf_clr;
  logic [PW-1:0] perf_cnt;
  int            checks = 0;
  int            errors = 0;

  pipe_stall_ctrl_if bus ();

  pipe_stall_ctrl #(.EXC_ENTRY(EXC), .PERF_W(PW)) dut (
    .clk        (clk),
    .rst        (rst),
    .ctl        (bus.slave),
    .perf_sel_i (perf_sel),
    .perf_clr_i (perf_clr),
    .perf_cnt_o (perf_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic [3:0]  req;
    logic        exc;
    logic        eret;
    logic [31:0] epc;
    logic        busy;
    logic [3:0]  e_stall;
    logic        e_flush;
    logic        e_rv;
    logic [31:0] e_pc;
    logic        e_drop;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic r, logic [3:0] q, logic x, logic e, logic [31:0] p,
                              logic b, logic [3:0] es, logic ef, logic ev,
                              logic [31:0] ep, logic ed);
    vec_t v;
    v.rst = r; v.req = q; v.exc = x; v.eret = e; v.epc = p; v.busy = b;
    v.e_stall = es; v.e_flush = ef; v.e_rv = ev; v.e_pc = ep; v.e_drop = ed;
    return v;
  endfunction

  task automatic drive(logic r, logic [3:0] q, logic x, logic e, logic [31:0] p,
                       logic b, logic [1:0] sel, logic clr);
    rst                = r;
    bus.stallreq_if_i  = q[0];
    bus.stallreq_id_i  = q[1];
    bus.stallreq_ex_i  = q[2];
    bus.stallreq_mem_i = q[3];
    bus.exception_i    = x;
    bus.eret_i         = e;
    bus.epc_i          = p;
    bus.if_busy_i      = b;
    perf_sel           = sel;
    perf_clr           = clr;
  endtask

  task automatic chk(string name, int idx, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s #%0d: got %h expected %h", name, idx, act, exp);
    end
  endtask

  task automatic chk_outs(string tag, int idx, logic [3:0] es, logic ef, logic ev,
                          logic [31:0] ep, logic ed);
    chk({tag, ".stall"}, idx, {28'h0, bus.stall_o}, {28'h0, es});
    chk({tag, ".flush"}, idx, {31'h0, bus.flush_o}, {31'h0, ef});
    chk({tag, ".rv"},    idx, {31'h0, bus.redirect_valid_o}, {31'h0, ev});
    chk({tag, ".pc"},    idx, bus.redirect_pc_o, ep);
    chk({tag, ".drop"},  idx, {31'h0, bus.drop_fetch_o}, {31'h0, ed});
  endtask

  // Apply inputs away from the edge, sample 1 ns later, then let the edge happen.
  task automatic step_read(int sel, int exp, string name, int idx);
    @(negedge clk);
    drive(1'b0, 4'b0000, 1'b0, 1'b0, 32'h0, 1'b0, sel[1:0], 1'b0);
    #1 chk(name, idx, {{(32-PW){1'b0}}, perf_cnt}, exp);
  endtask

  task automatic cycle(logic r, logic [3:0] q, logic clr);
    @(negedge clk);
    drive(r, q, 1'b0, 1'b0, 32'h0, 1'b0, 2'd0, clr);
  endtask

  // Behavioural model state
  bit          m_wait;
  logic [31:0] m_pc;
  int          m_cnt[4];

  initial begin
    // Directed table; req bits are {mem, ex, id, if}.
    vecs.push_back(mk(1, 4'b1111, 1, 1, 32'hFFFFFFFF, 1, 4'b0000, 0, 0, 32'h0, 0));
    vecs.push_back(mk(1, 4'b1111, 1, 1, 32'hFFFFFFFF, 1, 4'b0000, 0, 0, 32'h0, 0));
    vecs.push_back(mk(0, 4'b0100, 0, 0, 32'h0, 0, 4'b0111, 0, 0, 32'h0, 0));
    vecs.push_back(mk(0, 4'b0011, 0, 0, 32'h0, 0, 4'b0011, 0, 0, 32'h0, 0));
    vecs.push_back(mk(0, 4'b1000, 1, 0, 32'h0, 0, 4'b0000, 1, 1, EXC, 0));
    vecs.push_back(mk(0, 4'b0000, 0, 0, 32'h0, 0, 4'b0000, 0, 0, 32'h0, 0));
    vecs.push_back(mk(0, 4'b0000, 0, 1, 32'h80001234, 1, 4'b0000, 1, 1, 32'h80001234, 0));
    vecs.push_back(mk(0, 4'b1111, 0, 0, 32'h0, 1, 4'b0001, 0, 1, 32'h80001234, 1));
    vecs.push_back(mk(0, 4'b0000, 0, 0, 32'h0, 1, 4'b0001, 0, 1, 32'h80001234, 1));
    vecs.push_back(mk(0, 4'b0000, 0, 0, 32'h0, 0, 4'b0001, 0, 1, 32'h80001234, 1));
    vecs.push_back(mk(0, 4'b0000, 0, 0, 32'h0, 0, 4'b0000, 0, 0, 32'h0, 0));
    vecs.push_back(mk(0, 4'b0000, 1, 1, 32'h11110000, 0, 4'b0000, 1, 1, EXC, 0));
    vecs.push_back(mk(0, 4'b0000, 0, 1, 32'h0000A000, 1, 4'b0000, 1, 1, 32'h0000A000, 0));
    vecs.push_back(mk(0, 4'b0100, 1, 0, 32'h0000B000, 1, 4'b0001, 0, 1, 32'h0000A000, 1));
    vecs.push_back(mk(0, 4'b0000, 0, 1, 32'h0000C000, 0, 4'b0001, 0, 1, 32'h0000A000, 1));
    vecs.push_back(mk(0, 4'b0000, 0, 0, 32'h0, 0, 4'b0000, 0, 0, 32'h0, 0));
    vecs.push_back(mk(0, 4'b0000, 0, 1, 32'h80001234, 1, 4'b0000, 1, 1, 32'h80001234, 0));
    vecs.push_back(mk(0, 4'b0000, 0, 0, 32'h0, 1, 4'b0001, 0, 1, 32'h80001234, 1));
    vecs.push_back(mk(1, 4'b0000, 0, 0, 32'h0, 1, 4'b0000, 0, 0, 32'h0, 0));
    vecs.push_back(mk(0, 4'b0001, 0, 0, 32'h0, 1, 4'b0001, 0, 0, 32'h0, 0));
    vecs.push_back(mk(0, 4'b0000, 0, 0, 32'h0, 0, 4'b0000, 0, 0, 32'h0, 0));

    drive(1, 4'b1111, 1, 1, 32'hFFFFFFFF, 1, 2'd3, 1'b1);
    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      drive(vecs[i].rst, vecs[i].req, vecs[i].exc, vecs[i].eret, vecs[i].epc,
            vecs[i].busy, 2'd0, 1'b0);
      #1 chk_outs("vec", i, vecs[i].e_stall, vecs[i].e_flush, vecs[i].e_rv,
                  vecs[i].e_pc, vecs[i].e_drop);
      $display("vec %0d: stall=%b flush=%b rv=%b pc=%h drop=%b", i, bus.stall_o,
               bus.flush_o, bus.redirect_valid_o, bus.redirect_pc_o, bus.drop_fetch_o);
    end

    // Stall-cycle counters
    cycle(1'b1, 4'b0000, 1'b0);
    for (int i = 0; i < 5; i++) cycle(1'b0, 4'b0100, 1'b0);
    for (int i = 0; i < 2; i++) cycle(1'b0, 4'b1100, 1'b0);
    @(negedge clk);
    drive(0, 4'b1111, 1, 0, 32'h0, 0, 2'd0, 1'b0);  // flush cycle is not counted
`ifdef STALL_PERF_CNT_EN
    step_read(2, 5, "perf.ex", 0);
    step_read(3, 2, "perf.mem", 0);
    step_read(1, 0, "perf.id", 0);
    step_read(0, 0, "perf.if", 0);
    cycle(1'b0, 4'b0000, 1'b1);
    step_read(2, 0, "perf.clr_ex", 0);
    step_read(3, 0, "perf.clr_mem", 0);
    for (int i = 0; i < 9; i++) cycle(1'b0, 4'b0001, 1'b0);
    step_read(0, 7, "perf.sat", 0);
`else
    step_read(2, 0, "perf.off", 0);
    step_read(3, 0, "perf.off", 1);
`endif
    $display("perf sequence done: cnt=%0d", perf_cnt);

    // Randomized run against the model
    @(negedge clk);
    drive(1, 4'b0000, 0, 0, 32'h0, 0, 2'd0, 1'b0);
    @(posedge clk);
    m_wait = 0; m_pc = 32'h0;
    for (int k = 0; k < 4; k++) m_cnt[k] = 0;
    for (int n = 0; n < 2000; n++) begin
      logic        r, x, e, b, clr, ev;
      logic [3:0]  q, es;
      logic [31:0] p, ep;
      logic [1:0]  sel;
      logic        ef, erv, ed;
      int          top, ecnt;
      bit          was_run_ok;
      @(negedge clk);
      r   = ($urandom_range(39) == 0);
      x   = ($urandom_range(9) == 0);
      e   = ($urandom_range(9) == 0);
      b   = ($urandom_range(9) < 6);
      clr = ($urandom_range(29) == 0);
      q   = 4'($urandom) & 4'($urandom);
      p   = $urandom;
      sel = 2'($urandom);
      drive(r, q, x, e, p, b, sel, clr);
      ev = x | e;
      es = 4'b0000; ef = 0; erv = 0; ep = 32'h0; ed = 0;
      if (!r) begin
        if (m_wait) begin
          es = 4'b0001; erv = 1; ep = m_pc; ed = 1;
        end else if (ev) begin
          ef = 1; erv = 1; ep = x ? EXC : p;
        end else begin
          for (int k = 0; k < 4; k++)
            if (q[k]) es = es | 4'((5'd1 << (k + 1)) - 5'd1);
        end
      end
`ifdef STALL_PERF_CNT_EN
      ecnt = r ? 0 : m_cnt[sel];
`else
      ecnt = 0;
`endif
      #1;
      chk_outs("rnd", n, es, ef, erv, ep, ed);
      chk("rnd.perf", n, {{(32-PW){1'b0}}, perf_cnt}, ecnt);
      @(posedge clk);
      was_run_ok = !m_wait && !ev;
      if (r) begin
        m_wait = 0; m_pc = 32'h0;
        for (int k = 0; k < 4; k++) m_cnt[k] = 0;
      end else begin
        if (clr) begin
          for (int k = 0; k < 4; k++) m_cnt[k] = 0;
        end else if (was_run_ok && q != 4'b0000) begin
          top = 0;
          for (int k = 0; k < 4; k++) if (q[k]) top = k;
          if (m_cnt[top] < (2 ** PW) - 1) m_cnt[top]++;
        end
        if (!m_wait && ev) begin
          m_pc   = x ? EXC : p;
          m_wait = b;
        end else if (m_wait && !b) begin
          m_wait = 0;
        end
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/pipe_stall_ctrl.md
Name: pipe_stall_ctrl

Overview:
Central stall/flush controller for the 5-stage pipeline. It gathers per-stage stall requests, exception and eret events, and drives the shared stall vector, the flush strobe and the PC redirect. These feed the PC unit and the if_id/id_ex/ex_mem/mem_wb registers. A small FSM keeps a redirect pending while an instruction fetch is still in flight on the bus.

Parameters:
EXC_ENTRY, 32'hBFC00380, exception handler entry address
PERF_W, 32, width of each stall-cycle counter (used only with STALL_PERF_CNT_EN)

Ports:
clk  input  1  clock
rst  input  1  synchronous reset, active-high
stallreq_if_i  input  1  IF stage cannot complete (fetch not returned)
stallreq_id_i  input  1  ID hazard (load-use)
stallreq_ex_i  input  1  EX multi-cycle op busy (mul/div)
stallreq_mem_i  input  1  MEM data access not complete
exception_i  input  1  MEM stage commits an exception this cycle
eret_i  input  1  MEM stage commits eret this cycle
epc_i  input  32  eret return address
if_busy_i  input  1  IF bus read transaction outstanding
stall_o  output  4  bit k=1 holds stage k (0=IF,1=ID,2=EX,3=MEM)
flush_o  output  1  clear all pipeline registers to bubble
redirect_valid_o  output  1  PC must load redirect_pc_o
redirect_pc_o  output  32  redirect target
drop_fetch_o  output  1  discard the next returning fetch data
perf_sel_i  input  2  counter select (0=IF,1=ID,2=EX,3=MEM)
perf_clr_i  input  1  clear all counters
perf_cnt_o  output  PERF_W  selected counter value

Behaviour:
- Reset is synchronous and active-high; the clock is clk and the reset is rst.
- While rst=1: state=RUN, and every output is 0 regardless of the other inputs.
- States: RUN and WAIT_IF. The state register is the only sequential element apart from the latched redirect PC and the counters.
- Stall vector in RUN, combinational, same-cycle:
  - A request from stage k sets stall bits 0..k.
  - MEM request gives 4'b1111, EX gives 4'b0111, ID gives 4'b0011, IF gives 4'b0001.
  - Multiple requests are OR'd.
  - Each pipeline register updates only when its stall bit is 0. It inserts a bubble when stall[k]=1 and stall[k+1]=0.
- Exception or eret in RUN, same cycle (flush and redirect outputs combinational):
  - flush_o=1 and stall_o=4'b0000; all stall requests are ignored that cycle.
  - redirect_valid_o=1.
  - redirect_pc_o = EXC_ENTRY on exception, epc_i on eret.
  - If exception_i and eret_i are both high, the exception wins.
  - An exception wins over a simultaneous stallreq_mem_i.
  - The redirect target is latched into an internal register.
- If if_busy_i=1 in the flush cycle, next state is WAIT_IF. Otherwise the state stays RUN and the redirect lasts one cycle only.
- WAIT_IF state:
  - Outputs: stall_o=4'b0001, redirect_valid_o=1, redirect_pc_o=latched value, drop_fetch_o=1, flush_o=0.
  - exception_i, eret_i and all stallreq_* are ignored, since the pipeline holds only bubbles.
  - When if_busy_i=0, the PC accepts the redirect that cycle and next state is RUN.
  - redirect_valid_o and drop_fetch_o are 0 from the following cycle.
- drop_fetch_o is 0 in RUN.
- rst asserted in WAIT_IF: next cycle is RUN, the latched PC is cleared and no redirect is issued.

Optional Feature:
Macro: STALL_PERF_CNT_EN.
- Defined:
  - Four PERF_W-bit counters, one per cause.
  - Each cycle in RUN with no flush, the counter of the highest-numbered active request increments by 1. MEM > EX > ID > IF, so only one counter increments per cycle.
  - Counters saturate at all-ones.
  - perf_clr_i=1 zeroes all four next cycle, with priority over increment.
  - rst zeroes all four.
  - perf_cnt_o = counter[perf_sel_i], combinational.
- Not defined: no counter registers exist, perf_cnt_o is tied 0, and perf_sel_i/perf_clr_i are unused.

Test Plan:
- Reset and stall decode: rst=1 for 2 cycles with all inputs high → all outputs 0. Then stallreq_ex_i=1 alone → stall_o=4'b0111. stallreq_id_i with stallreq_if_i → 4'b0011.
- Exception, no fetch in flight: exception_i=1 with stallreq_mem_i=1 and if_busy_i=0 → same cycle flush_o=1, stall_o=0, redirect_valid_o=1, redirect_pc_o=32'hBFC00380. Next cycle redirect_valid_o=0 and state is RUN.
- Eret with fetch in flight: eret_i=1, epc_i=32'h80001234, if_busy_i=1 for 3 more cycles → flush 1 cycle. Then 3 cycles of WAIT_IF with stall_o=4'b0001, drop_fetch_o=1, redirect_pc_o=32'h80001234. The cycle if_busy_i=0 still shows redirect_valid_o=1, and it is 0 after that.
- Priority and masking: exception_i and eret_i high together → redirect_pc_o=EXC_ENTRY. exception_i pulsed during WAIT_IF → no new flush and the latched PC is unchanged.
- Reset mid-WAIT_IF: assert rst in the second WAIT_IF cycle → next cycle all outputs 0. After release, stallreq_if_i=1 → stall_o=4'b0001.
- With STALL_PERF_CNT_EN: 5 cycles stallreq_ex_i, then 2 cycles stallreq_mem_i together with stallreq_ex_i → perf_sel_i=2 reads 5 and perf_sel_i=3 reads 2. After perf_clr_i, both read 0.
